// File: rtl/bldc_startup_sequencer.sv
// bldc_startup_sequencer: align/ramp/settle/zero startup FSM with stall and overcurrent fault handling.
module bldc_startup_sequencer #(
  parameter int GAIN_W         = 16,
  parameter int RAMP_STEP      = 64,
  parameter int ALIGN_GAIN_MAX = 4096,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int STALL_TIMEOUT  = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              overcurrent,
  input  logic              fault_clear,
  input  logic              encoder_change,
  input  logic              velocity_cmd_nonzero,
  output logic              bridge_enable,
  output logic              apply_initial_commutation,
  output logic [GAIN_W-1:0] align_gain,
  output logic              reset_encoder_count,
  output logic              loop_enable,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [2:0]        state
);
  localparam int CNT_MAX = (SETTLE_CYCLES > STALL_TIMEOUT) ? SETTLE_CYCLES : STALL_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_TIMEOUT - 1);
  localparam logic [GAIN_W:0] STEP_W = (GAIN_W + 1)'(RAMP_STEP);
  localparam logic [GAIN_W:0] MAX_W = (GAIN_W + 1)'(ALIGN_GAIN_MAX);
  localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(ALIGN_GAIN_MAX);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    SETTLE = 3'd2,
    ZERO   = 3'd3,
    RUN    = 3'd4,
    FAULT  = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic [GAIN_W:0] gain_sum;
  logic stall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gain_q  <= '0;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
  // The sum is one bit wider than the gain so the clamp never sees a wrapped value.
  assign gain_sum = {1'b0, gain_q} + STEP_W;
  assign stall = (state_q == RUN) && !encoder_change && velocity_cmd_nonzero && (cnt_q == STALL_LAST);
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (overcurrent && state_q != FAULT) begin
      state_d = FAULT;
      cause_d = 2'b01;
      gain_d  = '0;
      cnt_d   = '0;
    end else if (stall) begin
      state_d = FAULT;
      cause_d = 2'b10;
      gain_d  = '0;
      cnt_d   = '0;
    end else if (stop && state_q inside {RAMP, SETTLE, ZERO, RUN}) begin
      state_d = IDLE;
      gain_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = (start && !stop) ? RAMP : IDLE;
          gain_d  = '0;
          cnt_d   = '0;
        end
        RAMP: begin
          state_d = (gain_sum >= MAX_W) ? SETTLE : RAMP;
          gain_d  = (gain_sum >= MAX_W) ? GAIN_MAX : gain_sum[GAIN_W-1:0];
          cnt_d   = '0;
        end
        SETTLE: begin
          state_d = (cnt_q == SETTLE_LAST) ? ZERO : SETTLE;
          cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CW'(1);
        end
        ZERO: begin
          state_d = RUN;
          gain_d  = '0;
          cnt_d   = '0;
        end
        RUN: cnt_d = (encoder_change || !velocity_cmd_nonzero) ? '0 : cnt_q + CW'(1);
        FAULT: begin
          state_d = (fault_clear && !overcurrent) ? IDLE : FAULT;
          cause_d = (fault_clear && !overcurrent) ? 2'b00 : cause_q;
        end
        default: begin
          state_d = IDLE;
          gain_d  = '0;
          cnt_d   = '0;
          cause_d = 2'b00;
        end
      endcase
    end
  end
  assign bridge_enable             = state_q inside {RAMP, SETTLE, ZERO, RUN};
  assign apply_initial_commutation = state_q inside {RAMP, SETTLE, ZERO};
  assign align_gain                = apply_initial_commutation ? gain_q : '0;
  assign reset_encoder_count       = state_q == ZERO;
  assign loop_enable               = state_q == RUN;
  assign fault                     = state_q == FAULT;
  assign fault_cause               = cause_q;
  assign state                     = state_q;
endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// tb_bldc_startup_sequencer: directed checks of startup, abort, stall, overcurrent and async reset behaviour.
module tb_bldc_startup_sequencer;
  localparam int STALL = 300;
  logic clk = 1'b0;
  logic reset, start, stop, overcurrent, fault_clear, encoder_change, velocity_cmd_nonzero;
  logic bridge_enable, apply_initial_commutation, reset_encoder_count, loop_enable, fault;
  logic [15:0] align_gain;
  logic [1:0] fault_cause;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;
  int rec_pulses = 0;
  bldc_startup_sequencer #(.STALL_TIMEOUT(STALL)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .overcurrent(overcurrent),
    .fault_clear(fault_clear),
    .encoder_change(encoder_change),
    .velocity_cmd_nonzero(velocity_cmd_nonzero),
    .bridge_enable(bridge_enable),
    .apply_initial_commutation(apply_initial_commutation),
    .align_gain(align_gain),
    .reset_encoder_count(reset_encoder_count),
    .loop_enable(loop_enable),
    .fault(fault),
    .fault_cause(fault_cause),
    .state(state)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reset_encoder_count) rec_pulses++;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_outs(input string tag, input int st, input int be, input int aic, input int g, input int rec,
                          input int le, input int f, input int fc);
    chk({tag, ".state"}, state, st);
    chk({tag, ".bridge"}, bridge_enable, be);
    chk({tag, ".apply"}, apply_initial_commutation, aic);
    chk({tag, ".gain"}, align_gain, g);
    chk({tag, ".rec"}, reset_encoder_count, rec);
    chk({tag, ".loop"}, loop_enable, le);
    chk({tag, ".fault"}, fault, f);
    chk({tag, ".cause"}, fault_cause, fc);
  endtask
  initial begin
    reset = 1'b1;
    {start, stop, overcurrent, fault_clear, encoder_change, velocity_cmd_nonzero} = '0;
    tick(2);
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk("idle_hold", state, 0);
    start = 1'b1;
    velocity_cmd_nonzero = 1'b1;
    tick();
    start = 1'b0;
    chk_outs("ramp0", 1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("ramp_gain", align_gain, i * 64);
      chk("ramp_state", state, 1);
    end
    tick();
    chk_outs("settle1", 2, 1, 1, 4096, 0, 0, 0, 0);
    tick(999);
    chk_outs("settle1000", 2, 1, 1, 4096, 0, 0, 0, 0);
    tick();
    chk_outs("zero", 3, 1, 1, 4096, 1, 0, 0, 0);
    tick();
    chk_outs("run", 4, 1, 0, 0, 0, 1, 0, 0);
    chk("rec_pulses", rec_pulses, 1);
    start = 1'b1;
    tick(STALL - 2);
    chk("run_start_held", state, 4);
    encoder_change = 1'b1;
    tick();
    encoder_change = 1'b0;
    chk("edge_at_last", state, 4);
    tick(STALL - 1);
    chk("run_before_stall", state, 4);
    tick();
    chk_outs("stall", 5, 0, 0, 0, 0, 0, 1, 2);
    tick();
    chk("fault_ignores_start", state, 5);
    start = 1'b0;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    chk_outs("stall_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(64);
    chk("abort_settle", state, 2);
    tick(499);
    stop = 1'b1;
    start = 1'b1;
    tick();
    chk_outs("stop_settle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stop_blocks_start", state, 0);
    chk("no_rec_after_stop", rec_pulses, 1);
    stop = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_ramp", state, 1);
    tick(3);
    chk("ramp_gain3", align_gain, 192);
    overcurrent = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_outs("oc_ramp", 5, 0, 0, 0, 0, 0, 1, 1);
    fault_clear = 1'b1;
    tick();
    chk_outs("clear_with_oc", 5, 0, 0, 0, 0, 0, 1, 1);
    fault_clear = 1'b0;
    overcurrent = 1'b0;
    tick();
    chk("oc_released", fault_cause, 1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    chk_outs("oc_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    chk("mid_ramp_gain", align_gain, 320);
    #2 reset = 1'b1;
    #1 chk_outs("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_outs("restart0", 1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("restart64", align_gain, 64);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
